// File: rtl/ddr_stim_pkg.sv
// Shared types and helpers for the DDR stimulus replayer.
// Holds the FSM state enum, the beat tag carried alongside each data word, and the byte reversal helper.
package ddr_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        SGAP,
        PGAP,
        DRAIN
    } state_e;

    typedef struct packed {
        logic sop;
        logic eop;
        logic last;
    } beat_tag_t;

    localparam int FIFO_DEPTH = 4;
    localparam int SWAP_MAX_W = 1024;

    // Reverses the lowest nbytes bytes of d; callers zero-extend into and truncate out of SWAP_MAX_W.
    function automatic logic [SWAP_MAX_W-1:0] byte_swap(input logic [SWAP_MAX_W-1:0] d,
                                                        input int nbytes);
        logic [SWAP_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SWAP_MAX_W / 8; i++) begin
            if (i < nbytes) begin
                r[i*8 +: 8] = d[(nbytes-1-i)*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_stim_fifo.sv
// Four-entry synchronous FIFO holding {tag, data} beats for the replayer output.
// Flush empties it in one cycle and overrides push/pop in that cycle.
module ddr_stim_fifo
    import ddr_stim_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [W-1:0]                  wdata_i,
    input  logic                          pop_i,
    output logic [W-1:0]                  rdata_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != 0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ddr_stim_replayer.sv
// Replays a word-addressed stimulus memory as tagged, segmented beats with gaps and repeated passes.
// Define DDR_STIM_BYTE_SWAP_EN to reverse the byte order of every beat as it enters the output FIFO.
module ddr_stim_replayer
    import ddr_stim_pkg::*;
#(
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 14,
    parameter int DEPTH_WORDS = 8192,
    parameter int SEG_WORDS   = 2048,
    parameter int SEG_GAP     = 1,
    parameter int PASS_GAP    = 30,
    parameter int NUM_PASSES  = 1
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              start,
    input  logic              abort,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pass_cnt,
    output state_e            dbg_state
);

    // Handshake: a beat moves downstream on a rising edge where out_vld && out_rdy; while
    // out_vld is high and out_rdy low, out_data and the tags hold their value.

    localparam int TAG_W = $bits(beat_tag_t);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W-1:0] SEG_LAST      = ADDR_W'(SEG_WORDS - 1);
    localparam logic [15:0]       SEG_GAP_LAST  = 16'(SEG_GAP - 1);
    localparam logic [15:0]       PASS_GAP_LAST = 16'(PASS_GAP - 1);
    localparam logic [15:0]       FINAL_PASS    = 16'(NUM_PASSES - 1);
    localparam logic [CW-1:0]     ISSUE_LIMIT   = CW'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] seg_idx_q, seg_idx_d;
    logic [15:0]       gap_q, gap_d;
    logic [15:0]       pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              inflight_q, inflight_d;
    beat_tag_t         infl_tag_q, infl_tag_d;

    logic [CW-1:0]            fifo_count;
    logic [TAG_W+DATA_W-1:0]  fifo_rdata;
    logic [DATA_W-1:0]        wr_data;
    logic [CW-1:0]            occ;
    logic                     issue;
    logic                     is_final;
    logic                     seg_end;
    logic                     pass_end;
    logic                     flush;
    beat_tag_t                issue_tag;
    beat_tag_t                head_tag;

    assign occ      = fifo_count + CW'(inflight_q);
    assign issue    = (state_q == STREAM) && !abort && (occ < ISSUE_LIMIT);
    assign is_final = (NUM_PASSES != 0) && (pass_q == FINAL_PASS);
    assign seg_end  = (seg_idx_q == SEG_LAST);
    assign pass_end = (addr_q == LAST_ADDR);
    assign flush    = abort && (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        seg_idx_d  = seg_idx_q;
        gap_d      = gap_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inflight_d = 1'b0;
        infl_tag_d = infl_tag_q;
        issue_tag.sop  = (seg_idx_q == '0);
        issue_tag.eop  = seg_end;
        issue_tag.last = seg_end && pass_end && is_final;

        if (issue) begin
            inflight_d = 1'b1;
            infl_tag_d = issue_tag;
            addr_d     = pass_end ? '0 : addr_q + 1'b1;
            seg_idx_d  = seg_end ? '0 : seg_idx_q + 1'b1;
            if (seg_end) begin
                gap_d = '0;
                if (pass_end) begin
                    if (is_final) begin
                        state_d = DRAIN;
                        pass_d  = pass_q + 16'd1;
                    end else if (PASS_GAP == 0) begin
                        pass_d = pass_q + 16'd1;
                    end else begin
                        state_d = PGAP;
                    end
                end else if (SEG_GAP != 0) begin
                    state_d = SGAP;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = STREAM;
                    addr_d    = '0;
                    seg_idx_d = '0;
                    pass_d    = '0;
                    busy_d    = 1'b1;
                end
            end
            SGAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == SEG_GAP_LAST) begin
                    state_d = STREAM;
                end
            end
            PGAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == PASS_GAP_LAST) begin
                    state_d   = STREAM;
                    pass_d    = pass_q + 16'd1;
                    addr_d    = '0;
                    seg_idx_d = '0;
                end
            end
            DRAIN: begin
                // Nothing in flight and nothing buffered means the final beat has left.
                if (!inflight_q && (fifo_count == '0)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (flush) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            seg_idx_q  <= '0;
            gap_q      <= '0;
            pass_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            infl_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            seg_idx_q  <= seg_idx_d;
            gap_q      <= gap_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            infl_tag_q <= infl_tag_d;
        end
    end

`ifdef DDR_STIM_BYTE_SWAP_EN
    logic [SWAP_MAX_W-1:0] swap_full;
    assign swap_full = byte_swap(SWAP_MAX_W'(mem_rdata), DATA_W / 8);
    assign wr_data   = swap_full[DATA_W-1:0];
`else
    assign wr_data = mem_rdata;
`endif

    ddr_stim_fifo #(
        .W (TAG_W + DATA_W)
    ) u_fifo (
        .clk_i   (M_AXI_ACLK),
        .rst_ni  (M_AXI_ARESETN),
        .flush_i (flush),
        .push_i  (inflight_q && !flush),
        .wdata_i ({infl_tag_q, wr_data}),
        .pop_i   (out_rdy),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign head_tag = beat_tag_t'(fifo_rdata[DATA_W +: TAG_W]);

    // Outputs read as zero whenever the FIFO is empty so idle and reset look identical downstream.
    assign out_vld   = (fifo_count != '0);
    assign out_data  = out_vld ? fifo_rdata[DATA_W-1:0] : '0;
    assign out_sop   = out_vld && head_tag.sop;
    assign out_eop   = out_vld && head_tag.eop;
    assign out_last  = out_vld && head_tag.last;
    assign mem_en    = issue;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_cnt  = pass_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr_stim_replayer.sv
// Directed-sequence bench for ddr_stim_replayer with a random memory image and a beat-list reference model.
// Honours DDR_STIM_BYTE_SWAP_EN when computing expected beat data.
module tb_ddr_stim_replayer;
    import ddr_stim_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int DEPTH = 16;
    localparam int SEG = 8;
    localparam int SG = 3;
    localparam int PG = 5;
    localparam int NP = 2;
`ifdef DDR_STIM_BYTE_SWAP_EN
    localparam logic [63:0] WORD0_OUT = 64'h0807060504030201;
`else
    localparam logic [63:0] WORD0_OUT = 64'h0102030405060708;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, out_rdy;
    logic          mem_en, out_vld, out_sop, out_eop, out_last, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata, out_data;
    logic [15:0]   pass_cnt;
    state_e        dbg_state;

    logic          start2, abort2, rdy2;
    logic          mem_en2, out_vld2, out_sop2, out_eop2, out_last2, busy2, done2;
    logic [AW-1:0] mem_addr2;
    logic [DW-1:0] mem_rdata2, out_data2;
    logic [15:0]   pass_cnt2;
    state_e        dbg_state2;

    always #5 clk = ~clk;

    ddr_stim_replayer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .SEG_WORDS(SEG),
                        .SEG_GAP(SG), .PASS_GAP(PG), .NUM_PASSES(NP)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .start(start), .abort(abort),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .out_last(out_last), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .dbg_state(dbg_state));

    ddr_stim_replayer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .SEG_WORDS(SEG),
                        .SEG_GAP(SG), .PASS_GAP(PG), .NUM_PASSES(0)) dut_inf (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .start(start2), .abort(abort2),
        .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .out_vld(out_vld2), .out_rdy(rdy2), .out_data(out_data2), .out_sop(out_sop2),
        .out_eop(out_eop2), .out_last(out_last2), .busy(busy2), .done(done2),
        .pass_cnt(pass_cnt2), .dbg_state(dbg_state2));

    logic [63:0] img [16];
    logic [66:0] exp_q [$];
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int beat_n = 0;
    int extra_n = 0;
    int done_n = 0;
    int done_cyc = 0;
    int beat_t [64];
    logic [63:0] first_data;
    bit          hold_v = 0;
    logic [66:0] held;
    int n2 = 0;
    int extra2_n = 0;
    int done2_n = 0;
    bit act2 = 0;

    // Latency-1 memory model shared by both instances.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_rdata <= img[mem_addr[3:0]];
        if (mem_en2) mem_rdata2 <= img[mem_addr2[3:0]];
    end

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input logic [63:0] w);
`ifdef DDR_STIM_BYTE_SWAP_EN
        logic [63:0] r;
        r = {<<8{w}};
        return r;
`else
        return w;
`endif
    endfunction

    task automatic fill_image();
        img[0] = 64'h0102030405060708;
        for (int i = 1; i < 16; i++) img[i] = {$urandom, $urandom};
    endtask

    // Reference: every pass replays words 0..DEPTH-1, segments of SEG words, last on final word of final pass.
    task automatic build_queue(input int passes);
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_q.push_back({(p == passes - 1) && (i == DEPTH - 1), (i % SEG) == SEG - 1,
                                 (i % SEG) == 0, exp_word(img[i])});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int mode, input int limit, input string tag);
        int d0;
        bit ok;
        d0 = done_n;
        ok = 0;
        for (int k = 0; k < limit; k++) begin
            tick();
            case (mode)
                0: out_rdy = 1'b1;
                1: out_rdy = ~k[0];
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
            if (done_n != d0 && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        out_rdy = 1'b1;
        check({tag, "_complete"}, 68'(ok), 68'd1);
    endtask

    task automatic wait_beats(input int n, input int limit, input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < limit; k++) begin
            if (beat_n >= n) begin
                ok = 1;
                break;
            end
            tick();
        end
        check({tag, "_reached"}, 68'(ok), 68'd1);
    endtask

    // Output monitor: scoreboard, stall stability and done tracking, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 0;
        end else begin
            if (mem_en) check("mem_addr_range", 68'(mem_addr < 5'd16), 68'd1);
            if (hold_v) check("stall_hold", {out_vld, out_last, out_eop, out_sop, out_data}, {1'b1, held});
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) extra_n++;
                else check("beat", {1'b0, out_last, out_eop, out_sop, out_data}, {1'b0, exp_q.pop_front()});
                if (beat_n == 0) first_data = out_data;
                if (beat_n < 64) beat_t[beat_n] = cyc;
                beat_n++;
            end
            hold_v = out_vld && !out_rdy && !abort;
            held = {out_last, out_eop, out_sop, out_data};
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (out_vld2 && rdy2) begin
                if (!act2) extra2_n++;
                else check("inf_beat", {1'b0, out_last2, out_eop2, out_sop2, out_data2},
                           {2'b00, (n2 % SEG) == SEG - 1, (n2 % SEG) == 0, exp_word(img[n2 % 16])});
                n2++;
            end
            if (done2) done2_n++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit ok;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_rdy = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; rdy2 = 1'b1;
        fill_image();
        repeat (3) tick();
        check("rst_out_vld", 68'(out_vld), 68'd0);
        check("rst_tags_data", {out_last, out_eop, out_sop, out_data}, 68'd0);
        check("rst_busy_done", {busy, done, mem_en}, 68'd0);
        check("rst_pass_cnt", 68'(pass_cnt), 68'd0);
        check("rst_state", 68'(dbg_state), 68'(IDLE));
        rst_n = 1'b1;
        tick();

        // Full run, out_rdy high: latency, gaps, tags, done, pass count.
        build_queue(NP); beat_n = 0; extra_n = 0;
        pulse_start();
        check("lat_c1", 68'(out_vld), 68'd0);
        tick();
        check("lat_c2", 68'(out_vld), 68'd0);
        tick();
        check("lat_c3", 68'(out_vld), 68'd1);
        check("busy_running", 68'(busy), 68'd1);
        run_to_done(0, 300, "t1");
        check("t1_beats", 68'(beat_n), 68'd32);
        check("t1_extra", 68'(extra_n), 68'd0);
        check("t1_seg_gap", 68'(beat_t[8] - beat_t[7] >= SG + 1), 68'd1);
        check("t1_pass_gap", 68'(beat_t[16] - beat_t[15] >= PG + 1), 68'd1);
        check("t1_done_after_last", 68'(done_cyc > beat_t[31]), 68'd1);
        check("t1_done_once", 68'(done_n), 68'd1);
        check("t1_pass_cnt", 68'(pass_cnt), 68'd2);
        check("t1_busy_idle", 68'(busy), 68'd0);
        check("word0_order", 68'(first_data), 68'(WORD0_OUT));

        // Alternating then random backpressure.
        fill_image(); build_queue(NP); beat_n = 0; extra_n = 0;
        pulse_start();
        run_to_done(1, 400, "t2_toggle");
        check("t2_beats", 68'(beat_n), 68'd32);
        check("t2_pass_cnt", 68'(pass_cnt), 68'd2);
        fill_image(); build_queue(NP); beat_n = 0;
        pulse_start();
        run_to_done(2, 600, "t2_random");
        check("t2r_beats", 68'(beat_n), 68'd32);
        check("t2_extra", 68'(extra_n), 68'd0);

        // Abort after beat 5, then a clean replay from word 0.
        fill_image(); build_queue(NP); beat_n = 0;
        d0 = done_n;
        pulse_start();
        wait_beats(6, 100, "t3_beat5");
        out_rdy = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; exp_q.delete();
        check("abort_vld", 68'(out_vld), 68'd0);
        check("abort_busy", 68'(busy), 68'd0);
        check("abort_state", 68'(dbg_state), 68'(IDLE));
        out_rdy = 1'b1;
        repeat (10) tick();
        check("abort_no_done", 68'(done_n), 68'(d0));
        check("abort_quiet", {out_vld, mem_en}, 68'd0);
        build_queue(NP); beat_n = 0; extra_n = 0;
        pulse_start();
        run_to_done(0, 300, "t3_replay");
        check("t3_beats", 68'(beat_n), 68'd32);
        check("t3_extra", 68'(extra_n), 68'd0);

        // start and abort together while idle: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 68'(busy), 68'd0);
        tick();
        check("sa_quiet", {out_vld, mem_en, busy}, 68'd0);

        // Asynchronous reset mid-segment.
        fill_image(); build_queue(NP); beat_n = 0;
        pulse_start();
        wait_beats(4, 100, "t5_mid");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_outputs", {out_vld, out_sop, out_eop, out_last, busy, done, mem_en}, 68'd0);
        check("arst_data_cnt", {out_data, pass_cnt}, 68'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        check("arst_idle", {out_vld, mem_en, busy}, 68'd0);
        check("arst_state", 68'(dbg_state), 68'(IDLE));

        // Endless passes: repeated start ignored, pass count climbs, no done, abort ends it.
        fill_image(); n2 = 0; extra2_n = 0; act2 = 1;
        start2 = 1'b1; tick(); start2 = 1'b0;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            tick();
            if (n2 >= 20) ok = 1;
        end
        check("inf_first20", 68'(ok), 68'd1);
        start2 = 1'b1; tick(); start2 = 1'b0;
        ok = 0;
        for (int k = 0; k < 600 && !ok; k++) begin
            if (n2 >= 64) ok = 1;
            else tick();
        end
        check("inf_64_beats", 68'(ok), 68'd1);
        check("inf_pass_cnt", 68'(pass_cnt2), 68'd3);
        check("inf_busy", 68'(busy2), 68'd1);
        for (int k = 0; k < 200 && n2 < 80; k++) tick();
        rdy2 = 1'b0; abort2 = 1'b1;
        tick();
        abort2 = 1'b0; act2 = 0;
        check("inf_abort", {out_vld2, busy2}, 68'd0);
        rdy2 = 1'b1;
        repeat (5) tick();
        check("inf_no_done", 68'(done2_n), 68'd0);
        check("inf_extra", 68'(extra2_n), 68'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
